eth_rx_dispatch: RTL and testbench

- Sits in the sys_clk domain directly downstream of the gigabit MAC wrapper's RX output (rx_f36 stream: 2-byte realign pad, then frame).
- Buffers the first 10 lines of each frame and classifies it: IPv4/UDP to our MAC and a configured UDP destination port goes to the DSP output; everything else goes to the CPU output.
- After classification, replays the buffered header and passes the rest of the packet straight through.

---
 rtl/eth_rx_dispatch_pkg.sv | 30 +++
 rtl/eth_rx_dispatch_demux.sv | 24 ++
 rtl/eth_rx_dispatch.sv | 162 ++++++++++++++++
 tb/tb_eth_rx_dispatch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_dispatch_pkg.sv
// Shared constants and types for the RX dispatcher.
// Covers fifo36 line fields, header offsets and FSM encoding.
package eth_rx_dispatch_pkg;

    localparam int HDR_LINES  = 10;
    localparam int F36_SOF    = 32;
    localparam int F36_EOF    = 33;
    localparam int F36_OCC_HI = 35;
    localparam int F36_OCC_LO = 34;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPPROTO_UDP    = 8'd17;

    localparam int DMAC_HI   = 0;
    localparam int DMAC_LO   = 1;
    localparam int ETYPE     = 3;
    localparam int PROTO     = 6;
    localparam int UDP_DPORT = 9;

    localparam logic [3:0] LAST_HDR = 4'(HDR_LINES - 1);

    typedef logic [35:0] f36_t;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_FLUSH,
        ST_PASS
    } state_t;

endpackage

// File: rtl/eth_rx_dispatch_demux.sv
// Two-way fifo36 demux: routes one line stream to DSP or CPU.
// The idle side sees zero data and no valid; ready comes from the chosen side.
module fifo36_demux2
    import eth_rx_dispatch_pkg::*;
(
    input  logic i_sel_dsp,
    input  f36_t i_data,
    input  logic i_src_rdy,
    output logic o_dst_rdy,
    output f36_t o_dsp_data,
    output logic o_dsp_src_rdy,
    input  logic i_dsp_dst_rdy,
    output f36_t o_cpu_data,
    output logic o_cpu_src_rdy,
    input  logic i_cpu_dst_rdy
);

    assign o_dsp_data    = i_sel_dsp ? i_data : '0;
    assign o_dsp_src_rdy = i_sel_dsp & i_src_rdy;
    assign o_cpu_data    = i_sel_dsp ? '0 : i_data;
    assign o_cpu_src_rdy = ~i_sel_dsp & i_src_rdy;
    assign o_dst_rdy     = i_sel_dsp ? i_dsp_dst_rdy : i_cpu_dst_rdy;

endmodule

// File: rtl/eth_rx_dispatch.sv
// Buffers the first header lines of each RX frame, classifies it,
// then replays the header and streams the rest to DSP or CPU.
module eth_rx_dispatch
    import eth_rx_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dispatch_en,
    input  logic [47:0] my_mac,
    input  logic [15:0] dsp_udp_port,
    input  logic [35:0] in_data,
    input  logic        in_src_rdy,
    output logic        in_dst_rdy,
    output logic [35:0] dsp_data,
    output logic        dsp_src_rdy,
    input  logic        dsp_dst_rdy,
    output logic [35:0] cpu_data,
    output logic        cpu_src_rdy,
    input  logic        cpu_dst_rdy,
    output logic [31:0] dsp_pkt_count,
    output logic [31:0] cpu_pkt_count
);

    state_t      r_state;
    state_t      w_state_nxt;
    f36_t        r_buf [HDR_LINES];
    logic [3:0]  r_wr_ptr;
    logic [3:0]  r_rd_ptr;
    logic [3:0]  r_last_ptr;
    logic        r_sel_dsp;
    logic        r_hdr_has_eof;
    logic        r_active;
    logic [31:0] r_dsp_cnt;
    logic [31:0] r_cpu_cnt;

    f36_t        w_out_data;
    logic        w_out_src_rdy;
    logic        w_sel_dst_rdy;
    logic        w_demux_dst_rdy;
    logic        w_sof;
    logic        w_eof;
    logic        w_hdr_fire;
    logic        w_hdr_wr;
    logic        w_decide;
    logic        w_match;
    logic        w_flush_fire;
    logic        w_flush_last;
    logic        w_pass_eof;
    logic        w_pkt_done;

    assign w_sof = in_data[F36_SOF];
    assign w_eof = in_data[F36_EOF];

    // Ready is held off until one cycle after reset release.
    assign w_hdr_fire = (r_state == ST_HDR) && r_active && in_src_rdy;
    assign w_hdr_wr   = w_hdr_fire && ((r_wr_ptr != 4'd0) || w_sof);
    assign w_decide   = w_hdr_wr && ((r_wr_ptr == LAST_HDR) || w_eof);

    assign w_match = dispatch_en
        && (r_wr_ptr == LAST_HDR)
        && ({r_buf[DMAC_HI][15:0], r_buf[DMAC_LO][31:0]} == my_mac)
        && (r_buf[ETYPE][15:0] == ETHERTYPE_IPV4)
        && (r_buf[PROTO][23:16] == IPPROTO_UDP)
        && (in_data[15:0] == dsp_udp_port);

    assign w_sel_dst_rdy = r_sel_dsp ? dsp_dst_rdy : cpu_dst_rdy;
    assign w_flush_fire  = (r_state == ST_FLUSH) && w_sel_dst_rdy;
    assign w_flush_last  = w_flush_fire && (r_rd_ptr == r_last_ptr);
    assign w_pass_eof    = (r_state == ST_PASS) && in_src_rdy
                        && w_sel_dst_rdy && w_eof;
    assign w_pkt_done    = (w_flush_last && r_hdr_has_eof) || w_pass_eof;

    always_comb begin
        w_state_nxt   = r_state;
        w_out_data    = '0;
        w_out_src_rdy = 1'b0;
        in_dst_rdy    = 1'b0;
        unique case (r_state)
            ST_HDR: begin
                in_dst_rdy = r_active;
                if (w_decide)
                    w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_out_data    = r_buf[r_rd_ptr];
                w_out_src_rdy = 1'b1;
                if (w_flush_last)
                    w_state_nxt = r_hdr_has_eof ? ST_HDR : ST_PASS;
            end
            ST_PASS: begin
                w_out_data    = in_data;
                w_out_src_rdy = in_src_rdy;
                in_dst_rdy    = w_sel_dst_rdy;
                if (w_pass_eof)
                    w_state_nxt = ST_HDR;
            end
            default: w_state_nxt = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_HDR;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < HDR_LINES; i++)
                r_buf[i] <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_last_ptr    <= '0;
            r_sel_dsp     <= 1'b0;
            r_hdr_has_eof <= 1'b0;
            r_active      <= 1'b0;
            r_dsp_cnt     <= '0;
            r_cpu_cnt     <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_hdr_wr) begin
                r_buf[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + 4'd1;
            end
            if (w_decide) begin
                r_wr_ptr      <= '0;
                r_last_ptr    <= r_wr_ptr;
                r_sel_dsp     <= w_match;
                r_hdr_has_eof <= w_eof;
            end
            if (w_flush_fire)
                r_rd_ptr <= w_flush_last ? 4'd0 : r_rd_ptr + 4'd1;
            if (w_pkt_done) begin
                if (r_sel_dsp)
                    r_dsp_cnt <= r_dsp_cnt + 32'd1;
                else
                    r_cpu_cnt <= r_cpu_cnt + 32'd1;
            end
        end
    end

    fifo36_demux2 u_demux (
        .i_sel_dsp     (r_sel_dsp),
        .i_data        (w_out_data),
        .i_src_rdy     (w_out_src_rdy),
        .o_dst_rdy     (w_demux_dst_rdy),
        .o_dsp_data    (dsp_data),
        .o_dsp_src_rdy (dsp_src_rdy),
        .i_dsp_dst_rdy (dsp_dst_rdy),
        .o_cpu_data    (cpu_data),
        .o_cpu_src_rdy (cpu_src_rdy),
        .i_cpu_dst_rdy (cpu_dst_rdy)
    );

    assign dsp_pkt_count = r_dsp_cnt;
    assign cpu_pkt_count = r_cpu_cnt;

    logic w_unused;
    assign w_unused = w_demux_dst_rdy;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Directed bench for eth_rx_dispatch: packets in, per-port line capture,
// compared against the driven frame and hand-counted packet totals.
module tb_eth_rx_dispatch;

    localparam logic [47:0] MAC  = 48'h0050_C285_3FFF;
    localparam logic [15:0] PORT = 16'd49152;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dispatch_en;
    logic [47:0] my_mac;
    logic [15:0] dsp_udp_port;
    logic [35:0] in_data;
    logic        in_src_rdy;
    logic        in_dst_rdy;
    logic [35:0] dsp_data;
    logic        dsp_src_rdy;
    logic        dsp_dst_rdy;
    logic [35:0] cpu_data;
    logic        cpu_src_rdy;
    logic        cpu_dst_rdy;
    logic [31:0] dsp_pkt_count;
    logic [31:0] cpu_pkt_count;

    int total = 0;
    int bad   = 0;

    logic [35:0] pkt[$];
    logic [35:0] exp_q[$];
    logic [35:0] dsp_q[$];
    logic [35:0] cpu_q[$];
    int          in_idx;
    int          cyc = 0;
    int          flush_bad;
    bit          dsp_seen;
    bit          cpu_seen;
    bit          done;
    logic [3:0]  patv = 4'b1001;

    eth_rx_dispatch dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dispatch_en   (dispatch_en),
        .my_mac        (my_mac),
        .dsp_udp_port  (dsp_udp_port),
        .in_data       (in_data),
        .in_src_rdy    (in_src_rdy),
        .in_dst_rdy    (in_dst_rdy),
        .dsp_data      (dsp_data),
        .dsp_src_rdy   (dsp_src_rdy),
        .dsp_dst_rdy   (dsp_dst_rdy),
        .cpu_data      (cpu_data),
        .cpu_src_rdy   (cpu_src_rdy),
        .cpu_dst_rdy   (cpu_dst_rdy),
        .dsp_pkt_count (dsp_pkt_count),
        .cpu_pkt_count (cpu_pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic void make_pkt(int n, logic [47:0] mac,
                                     logic [15:0] etype, logic [7:0] proto,
                                     logic [15:0] dport);
        logic [31:0] w;
        logic [35:0] l;
        for (int i = 0; i < n; i++) begin
            case (i)
                0: w = {16'h0000, mac[47:32]};
                1: w = mac[31:0];
                2: w = 32'h0011_2233;
                3: w = {16'h4455, etype};
                4: w = 32'h4500_0000 | 32'(n);
                5: w = 32'h1234_4000;
                6: w = {8'h40, proto, 16'hBEEF};
                7: w = 32'hC0A8_0A01;
                8: w = 32'hC0A8_0A02;
                9: w = {16'h1F90, dport};
                default: w = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
            endcase
            l = {(i == n - 1) ? 2'd2 : 2'd0, i == n - 1, i == 0, w};
            pkt.push_back(l);
            exp_q.push_back(l);
        end
    endfunction

    task automatic new_pkt();
        pkt.delete();
        exp_q.delete();
    endtask

    task automatic run(bit pat, bit rnd, int stop_at);
        in_idx = 0;
        dsp_q.delete();
        cpu_q.delete();
        flush_bad = 0;
        dsp_seen  = 0;
        cpu_seen  = 0;
        done      = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (in_idx < pkt.size() && (!rnd || $urandom_range(0, 2) != 0)) begin
                in_src_rdy = 1'b1;
                in_data    = pkt[in_idx];
            end else begin
                in_src_rdy = 1'b0;
                in_data    = '0;
            end
            dsp_dst_rdy = pat ? patv[cyc % 4] : 1'b1;
            cpu_dst_rdy = 1'b1;
            cyc++;
            #4;
            if ((dsp_src_rdy || cpu_src_rdy) && in_dst_rdy
                && (dsp_q.size() + cpu_q.size() < 10))
                flush_bad++;
            if (dsp_src_rdy) dsp_seen = 1;
            if (cpu_src_rdy) cpu_seen = 1;
            if (in_src_rdy && in_dst_rdy) in_idx++;
            if (dsp_src_rdy && dsp_dst_rdy) dsp_q.push_back(dsp_data);
            if (cpu_src_rdy && cpu_dst_rdy) cpu_q.push_back(cpu_data);
            @(posedge clk);
            #1;
            if (stop_at > 0 && in_idx == stop_at) begin
                done = 1;
                break;
            end
            if (in_idx == pkt.size()
                && dsp_q.size() + cpu_q.size() == exp_q.size()) begin
                done = 1;
                break;
            end
        end
    endtask

    task automatic verify(string tag, bit to_dsp);
        check({tag, "_done"}, 64'(done), 64'd1);
        if (to_dsp) begin
            check({tag, "_dsp_len"}, 64'(dsp_q.size()), 64'(exp_q.size()));
            check({tag, "_cpu_idle"}, 64'(cpu_seen), 64'd0);
            for (int i = 0; i < dsp_q.size() && i < exp_q.size(); i++)
                check($sformatf("%s_line%0d", tag, i), 64'(dsp_q[i]), 64'(exp_q[i]));
        end else begin
            check({tag, "_cpu_len"}, 64'(cpu_q.size()), 64'(exp_q.size()));
            check({tag, "_dsp_idle"}, 64'(dsp_seen), 64'd0);
            for (int i = 0; i < cpu_q.size() && i < exp_q.size(); i++)
                check($sformatf("%s_line%0d", tag, i), 64'(cpu_q[i]), 64'(exp_q[i]));
        end
        check({tag, "_flush_rdy"}, 64'(flush_bad), 64'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        dispatch_en  = 1'b1;
        my_mac       = MAC;
        dsp_udp_port = PORT;
        in_data      = '0;
        in_src_rdy   = 1'b0;
        dsp_dst_rdy  = 1'b1;
        cpu_dst_rdy  = 1'b1;
        #2;
        check("rst_in_rdy", 64'(in_dst_rdy), 64'd0);
        check("rst_dsp_src", 64'(dsp_src_rdy), 64'd0);
        check("rst_cpu_src", 64'(cpu_src_rdy), 64'd0);
        check("rst_dsp_data", 64'(dsp_data), 64'd0);
        check("rst_cpu_data", 64'(cpu_data), 64'd0);
        check("rst_dsp_cnt", 64'(dsp_pkt_count), 64'd0);
        check("rst_cpu_cnt", 64'(cpu_pkt_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_rdy", 64'(in_dst_rdy), 64'd1);

        new_pkt();
        make_pkt(20, MAC, 16'h0800, 8'd17, PORT);
        run(0, 0, 0);
        verify("udp_dsp", 1);
        check("udp_dsp_cnt", 64'(dsp_pkt_count), 64'd1);

        new_pkt();
        make_pkt(20, MAC, 16'h0800, 8'd17, 16'd49153);
        run(0, 0, 0);
        verify("port_miss", 0);
        check("port_miss_cnt", 64'(cpu_pkt_count), 64'd1);

        dispatch_en = 1'b0;
        new_pkt();
        make_pkt(20, MAC, 16'h0800, 8'd17, PORT);
        run(0, 0, 0);
        verify("disabled", 0);
        check("disabled_cnt", 64'(cpu_pkt_count), 64'd2);
        dispatch_en = 1'b1;

        new_pkt();
        make_pkt(8, MAC, 16'h0806, 8'd0, 16'd0);
        run(0, 0, 0);
        verify("arp", 0);
        check("arp_cnt", 64'(cpu_pkt_count), 64'd3);

        new_pkt();
        make_pkt(10, MAC, 16'h0800, 8'd17, PORT);
        run(0, 0, 0);
        verify("ten_line", 1);
        check("ten_line_cnt", 64'(dsp_pkt_count), 64'd2);

        new_pkt();
        make_pkt(1, MAC, 16'h0800, 8'd17, PORT);
        run(0, 0, 0);
        verify("one_line", 0);
        check("one_line_cnt", 64'(cpu_pkt_count), 64'd4);

        new_pkt();
        make_pkt(30, MAC, 16'h0800, 8'd17, PORT);
        run(1, 1, 0);
        verify("bp", 1);
        check("bp_cnt", 64'(dsp_pkt_count), 64'd3);
        check("bp_cpu_cnt", 64'(cpu_pkt_count), 64'd4);

        new_pkt();
        make_pkt(30, MAC, 16'h0800, 8'd17, PORT);
        run(0, 0, 15);
        check("mid_done", 64'(done), 64'd1);
        @(negedge clk);
        in_src_rdy  = 1'b1;
        in_data     = pkt[15];
        dsp_dst_rdy = 1'b1;
        #1;
        check("mid_pass_src", 64'(dsp_src_rdy), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_dsp_src", 64'(dsp_src_rdy), 64'd0);
        check("mid_rst_cpu_src", 64'(cpu_src_rdy), 64'd0);
        check("mid_rst_in_rdy", 64'(in_dst_rdy), 64'd0);
        check("mid_rst_dsp_cnt", 64'(dsp_pkt_count), 64'd0);
        check("mid_rst_cpu_cnt", 64'(cpu_pkt_count), 64'd0);
        in_src_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        pkt = pkt[15:$];
        exp_q.delete();
        make_pkt(20, MAC, 16'h0800, 8'd17, PORT);
        run(0, 0, 0);
        verify("post_rst", 1);
        check("post_rst_dsp_cnt", 64'(dsp_pkt_count), 64'd1);
        check("post_rst_cpu_cnt", 64'(cpu_pkt_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
